// File: rtl/mux_scan_seq.sv
// mux_scan_seq: steps S over channels 0..3 of a downstream mux/encoder,
// waits SETTLE extra cycles per channel, captures F into a shadow result,
// and publishes {F3,F2,F1,F0}, the largest F and its channel on completion.
// Ports: clk, rst_n (sync, active-low), start, abort, cont, F[2:0] in;
//        S[1:0], busy, done, res[11:0], max_f[2:0], max_ch[1:0] out.
module mux_scan_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        cont,
  input  logic [2:0]  F,
  output logic [1:0]  S,
  output logic        busy,
  output logic        done,
  output logic [11:0] res,
  output logic [2:0]  max_f,
  output logic [1:0]  max_ch
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] SET = 4'(SETTLE);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  s_n;
  logic        busy_n, done_n;
  logic [11:0] res_n;
  logic [2:0]  max_f_n;
  logic [1:0]  max_ch_n;
  logic [11:0] sh_res, sh_res_n;
  logic [2:0]  sh_max, sh_max_n;
  logic [1:0]  sh_ch, sh_ch_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      S      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= '0;
      max_f  <= '0;
      max_ch <= '0;
      sh_res <= '0;
      sh_max <= '0;
      sh_ch  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      S      <= s_n;
      busy   <= busy_n;
      done   <= done_n;
      res    <= res_n;
      max_f  <= max_f_n;
      max_ch <= max_ch_n;
      sh_res <= sh_res_n;
      sh_max <= sh_max_n;
      sh_ch  <= sh_ch_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    s_n      = S;
    res_n    = res;
    max_f_n  = max_f;
    max_ch_n = max_ch;
    sh_res_n = sh_res;
    sh_max_n = sh_max;
    sh_ch_n  = sh_ch;
    unique case (state)
      IDLE: begin
        s_n   = '0;
        cnt_n = '0;
        if (start && !abort)
          state_n = WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_n = IDLE;
          s_n     = '0;
          cnt_n   = '0;
        end else if (cnt == SET) begin
          cnt_n = '0;
          sh_res_n[32'(S) * 3 +: 3] = F;
          // channel 0 seeds the max; strict compare keeps
          // the lowest channel on ties
          if (S == 2'd0) begin
            sh_max_n = F;
            sh_ch_n  = 2'd0;
          end else if (F > sh_max) begin
            sh_max_n = F;
            sh_ch_n  = S;
          end
          if (S == 2'd3) begin
            state_n  = DONE;
            res_n    = sh_res_n;
            max_f_n  = sh_max_n;
            max_ch_n = sh_ch_n;
          end else begin
            s_n = S + 2'd1;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        s_n   = '0;
        cnt_n = '0;
        if (cont && !abort)
          state_n = WAIT;
        else
          state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        s_n     = '0;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: checks mux_scan_seq (SETTLE=1 and SETTLE=0 copies)
// against a scan-level reference model of the mux/encoder scan.
module tb_mux_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n, abort, cont;
  logic        start_a, start_b;
  logic [2:0]  f_a, f_b;
  logic [1:0]  s_a, s_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [11:0] res_a, res_b;
  logic [2:0]  mf_a, mf_b;
  logic [1:0]  mc_a, mc_b;
  logic [7:0]  in_v [4];

  logic [11:0] exp_res [2];
  logic [2:0]  exp_mf [2];
  logic [1:0]  exp_mc [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_scan_seq #(.SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .cont(cont), .F(f_a), .S(s_a), .busy(busy_a), .done(done_a),
    .res(res_a), .max_f(mf_a), .max_ch(mc_a)
  );

  mux_scan_seq #(.SETTLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .cont(cont), .F(f_b), .S(s_b), .busy(busy_b), .done(done_b),
    .res(res_b), .max_f(mf_b), .max_ch(mc_b)
  );

  // mux + priority encoder: index of highest set bit, 0 for zero
  function automatic logic [2:0] msb(input logic [7:0] x);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = 3'(i);
    return r;
  endfunction

  always_comb f_a = msb(in_v[s_a]);
  always_comb f_b = msb(in_v[s_b]);

  function automatic logic [1:0] os(input int d);
    return (d != 0) ? s_b : s_a;
  endfunction
  function automatic logic obusy(input int d);
    return (d != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic odone(input int d);
    return (d != 0) ? done_b : done_a;
  endfunction
  function automatic logic [11:0] ores(input int d);
    return (d != 0) ? res_b : res_a;
  endfunction
  function automatic logic [2:0] omf(input int d);
    return (d != 0) ? mf_b : mf_a;
  endfunction
  function automatic logic [1:0] omc(input int d);
    return (d != 0) ? mc_b : mc_a;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int d, input logic v);
    if (d != 0) start_b = v;
    else start_a = v;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 4; i++)
      in_v[i] = 8'($urandom) >> $urandom_range(0, 8);
  endtask

  // whole-scan reference: fields, max with lowest channel on tie
  task automatic model_scan(output logic [11:0] r, output logic [2:0] m,
                            output logic [1:0] c);
    r = {msb(in_v[3]), msb(in_v[2]), msb(in_v[1]), msb(in_v[0])};
    m = msb(in_v[0]);
    c = 2'd0;
    for (int ch = 1; ch < 4; ch++)
      if (msb(in_v[ch]) > m) begin
        m = msb(in_v[ch]);
        c = 2'(ch);
      end
  endtask

  task automatic chk_hold(input int d, input string tag);
    chk({tag, "_res"}, ores(d), exp_res[d]);
    chk({tag, "_maxf"}, 12'(omf(d)), 12'(exp_mf[d]));
    chk({tag, "_maxch"}, 12'(omc(d)), 12'(exp_mc[d]));
  endtask

  task automatic do_scan(input int d, input int nscans, input bit rnd,
                         input bit poke);
    int per;
    int n;
    logic [11:0] r;
    logic [2:0]  m;
    logic [1:0]  c;
    per  = (d == 0) ? 2 : 1;
    n    = 4 * per;
    cont = (nscans > 1);
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    for (int j = 0; j < nscans; j++) begin
      r = '0; m = '0; c = '0;
      for (int k = 1; k <= n; k++) begin
        chk("scan_S", 12'(os(d)), 12'((k - 1) / per));
        chk("scan_busy", 12'(obusy(d)), 12'd1);
        chk("scan_done", 12'(odone(d)), 12'd0);
        if (k == 1) begin
          chk_hold(d, "scan_hold");
          if (rnd) rand_inputs();
          model_scan(r, m, c);
          if (j == nscans - 1) cont = 1'b0;
        end
        if (poke && k == 2) set_start(d, 1'b1);
        if (poke && k == 3) set_start(d, 1'b0);
        tick();
      end
      chk("end_done", 12'(odone(d)), 12'd1);
      chk("end_busy", 12'(obusy(d)), 12'd1);
      exp_res[d] = r;
      exp_mf[d]  = m;
      exp_mc[d]  = c;
      chk_hold(d, "end");
      tick();
    end
    chk("after_busy", 12'(obusy(d)), 12'd0);
    chk("after_done", 12'(odone(d)), 12'd0);
    chk("after_S", 12'(os(d)), 12'd0);
    chk_hold(d, "after");
  endtask

  task automatic do_abort(input int d, input int ch);
    int per;
    per = (d == 0) ? 2 : 1;
    rand_inputs();
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    for (int k = 1; k < ch * per + 1; k++) tick();
    chk("abort_S", 12'(os(d)), 12'(ch));
    abort = 1'b1;
    cont  = 1'b1;
    set_start(d, 1'b1);
    tick();
    abort = 1'b0;
    cont  = 1'b0;
    set_start(d, 1'b0);
    chk("abort_busy", 12'(obusy(d)), 12'd0);
    chk("abort_S0", 12'(os(d)), 12'd0);
    chk("abort_done", 12'(odone(d)), 12'd0);
    chk_hold(d, "abort");
    for (int k = 0; k < 4 * per + 2; k++) begin
      tick();
      chk("abort_nodone", 12'(odone(d)), 12'd0);
    end
    abort = 1'b1;
    set_start(d, 1'b1);
    tick();
    abort = 1'b0;
    set_start(d, 1'b0);
    chk("idle_abort_prio", 12'(obusy(d)), 12'd0);
  endtask

  task automatic do_reset_mid(input int d);
    int per;
    per = (d == 0) ? 2 : 1;
    rand_inputs();
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    for (int k = 1; k < per + 1; k++) tick();
    chk("rst_pre_S", 12'(os(d)), 12'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_res[i] = '0;
      exp_mf[i]  = '0;
      exp_mc[i]  = '0;
    end
    chk("rst_S", 12'(os(d)), 12'd0);
    chk("rst_busy", 12'(obusy(d)), 12'd0);
    chk("rst_done", 12'(odone(d)), 12'd0);
    chk_hold(d, "rst");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_nodone", 12'(odone(d)), 12'd0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    abort   = 1'b0;
    cont    = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 4; i++) in_v[i] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      exp_res[i] = '0;
      exp_mf[i]  = '0;
      exp_mc[i]  = '0;
    end
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_S", 12'(os(d)), 12'd0);
      chk("reset_busy", 12'(obusy(d)), 12'd0);
      chk("reset_done", 12'(odone(d)), 12'd0);
      chk_hold(d, "reset");
    end

    in_v[0] = 8'd156; in_v[1] = 8'd23; in_v[2] = 8'd56; in_v[3] = 8'd7;
    do_scan(0, 1, 1'b0, 1'b1);
    chk("dir_res_567", res_a, 12'h567);

    for (int i = 0; i < 4; i++) in_v[i] = 8'h80;
    do_scan(0, 1, 1'b0, 1'b0);
    chk("dir_tie_ch", 12'(mc_a), 12'd0);

    in_v[0] = 8'h01; in_v[1] = 8'h02; in_v[2] = 8'h10; in_v[3] = 8'h10;
    do_scan(0, 2, 1'b0, 1'b0);
    chk("dir_cont_ch", 12'(mc_a), 12'd2);

    do_abort(0, 2);
    do_reset_mid(0);

    in_v[0] = 8'd156; in_v[1] = 8'd23; in_v[2] = 8'd56; in_v[3] = 8'd7;
    do_scan(1, 1, 1'b0, 1'b0);
    chk("dir_s0_res", res_b, 12'h567);

    for (int it = 0; it < 16; it++) begin
      int d;
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: do_scan(d, 1, 1'b1, 1'b0);
        1: do_scan(d, int'($urandom_range(2, 3)), 1'b1, 1'b0);
        2: do_abort(d, int'($urandom_range(0, 3)));
        default: do_scan(d, 1, 1'b1, 1'b1);
      endcase
    end
    do_reset_mid(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
